// File: rtl/mha_pkg.sv
// Shared scheduler types and sizing helpers for the systolic tile scheduler.
// Holds the state encoding plus the flush-length and counter-width derivations.
package mha_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Cycles for the last operand to skew in and the last column to deskew out.
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic int cnt_width(input int k_width, input int flen);
    int max_v;
    max_v = (1 << k_width) - 1;
    if (flen > max_v) max_v = flen;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/systolic_tile_sched_if.sv
// Tile request / operand read / result handshake bundle of the tile scheduler.
// master = requester and result consumer, slave = scheduler.
interface systolic_tile_sched_if #(
  parameter int K_WIDTH = 8
);
  logic               start_valid;
  logic               start_ready;
  logic [K_WIDTH-1:0] k_len;
  logic               in_rd_en;
  logic [K_WIDTH-1:0] in_rd_addr;
  logic               acc_clr;
  logic               pe_en;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output start_valid, k_len, out_ready,
    input  start_ready, in_rd_en, in_rd_addr, acc_clr, pe_en, out_valid, busy
  );

  modport slave (
    input  start_valid, k_len, out_ready,
    output start_ready, in_rd_en, in_rd_addr, acc_clr, pe_en, out_valid, busy
  );
endinterface

// File: rtl/sched_down_cnt.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
// Used for both the LOAD and FLUSH phase lengths.
module sched_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/systolic_tile_sched.sv
// Sequences one systolic tile: operand reads (LOAD), pipeline drain (FLUSH), result hold (DONE).
// Optional perf counters perf_tiles/perf_busy are built when SYSTOLIC_SCHED_PERF_CNT_EN is defined.
module systolic_tile_sched
  import mha_pkg::*;
#(
  parameter int SYSTOLIC_ROW    = 4,
  parameter int SYSTOLIC_COLUMN = 16,
  parameter int K_WIDTH         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  systolic_tile_sched_if.slave    sched_if
`ifdef SYSTOLIC_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]             perf_tiles,
  output logic [31:0]             perf_busy
`endif
);

  localparam int FLUSH_LEN = flush_len(SYSTOLIC_ROW, SYSTOLIC_COLUMN);
  localparam int CNT_W     = cnt_width(K_WIDTH, FLUSH_LEN);

  sched_state_t       r_state;
  sched_state_t       w_next;
  logic               w_load_ld;
  logic               w_load_dec;
  logic               w_flush_ld;
  logic               w_flush_dec;
  logic [CNT_W-1:0]   w_load_cnt;
  logic [CNT_W-1:0]   w_flush_cnt;
  logic               r_acc_clr;
  logic [K_WIDTH-1:0] r_addr;

  sched_down_cnt #(.W(CNT_W)) u_load_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load_ld),
    .i_load_val (CNT_W'(sched_if.k_len)),
    .i_dec      (w_load_dec),
    .o_cnt      (w_load_cnt)
  );

  sched_down_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_flush_ld),
    .i_load_val (CNT_W'(FLUSH_LEN)),
    .i_dec      (w_flush_dec),
    .o_cnt      (w_flush_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_ld   = 1'b0;
    w_load_dec  = 1'b0;
    w_flush_ld  = 1'b0;
    w_flush_dec = 1'b0;
    case (r_state)
      IDLE: begin
        if (sched_if.start_valid) begin
          w_load_ld = 1'b1;
          w_next    = (sched_if.k_len != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        w_load_dec = 1'b1;
        if (w_load_cnt == CNT_W'(1)) begin
          w_flush_ld = 1'b1;
          w_next     = FLUSH;
        end
      end
      FLUSH: begin
        w_flush_dec = 1'b1;
        if (w_flush_cnt == CNT_W'(1)) w_next = DONE;
      end
      DONE: begin
        if (sched_if.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Address only advances while another LOAD cycle follows, so it rests at 0 otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_clr <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_acc_clr <= w_load_ld;
      r_addr    <= (r_state == LOAD && w_next == LOAD) ? r_addr + K_WIDTH'(1) : '0;
    end
  end

  assign sched_if.start_ready = (r_state == IDLE);
  assign sched_if.busy        = (r_state != IDLE);
  assign sched_if.in_rd_en    = (r_state == LOAD);
  assign sched_if.in_rd_addr  = r_addr;
  assign sched_if.acc_clr     = r_acc_clr;
  assign sched_if.pe_en       = (r_state == LOAD) || (r_state == FLUSH);
  assign sched_if.out_valid   = (r_state == DONE);

`ifdef SYSTOLIC_SCHED_PERF_CNT_EN
  logic [31:0] r_perf_tiles;
  logic [31:0] r_perf_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_tiles <= '0;
      r_perf_busy  <= '0;
    end else begin
      if ((r_state == DONE) && sched_if.out_ready) r_perf_tiles <= r_perf_tiles + 32'd1;
      if (r_state != IDLE)                         r_perf_busy  <= r_perf_busy + 32'd1;
    end
  end

  assign perf_tiles = r_perf_tiles;
  assign perf_busy  = r_perf_busy;
`endif

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Bench for systolic_tile_sched: per-cycle compare against a tile-timeline model,
// directed literal checks, and randomized tile lengths / result hold times.
module tb_systolic_tile_sched;

  localparam int ROW = 4;
  localparam int COL = 16;
  localparam int KW  = 8;
  localparam int FL  = ROW + COL - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  systolic_tile_sched_if #(.K_WIDTH(KW)) bus ();

`ifdef SYSTOLIC_SCHED_PERF_CNT_EN
  logic [31:0] perf_tiles;
  logic [31:0] perf_busy;
`endif

  systolic_tile_sched #(
    .SYSTOLIC_ROW    (ROW),
    .SYSTOLIC_COLUMN (COL),
    .K_WIDTH         (KW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sched_if   (bus.slave)
`ifdef SYSTOLIC_SCHED_PERF_CNT_EN
    ,
    .perf_tiles (perf_tiles),
    .perf_busy  (perf_busy)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: a tile is "active" from accept; m_d counts cycles since accept.
  bit m_active = 1'b0;
  int m_k = 0;
  int m_d = 0;
  bit e_rd, e_clr, e_ov, e_pe;
  int e_addr, pe_end;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (!reset) m_active = 1'b0;
      pe_end = (m_k == 0) ? 0 : m_k + FL;
      e_pe   = m_active && (m_d <= pe_end);
      e_rd   = m_active && (m_d <= m_k);
      e_addr = e_rd ? m_d - 1 : 0;
      e_clr  = m_active && (m_d == 1);
      e_ov   = m_active && (m_d > pe_end);
      check("cyc_start_ready", bus.start_ready, !m_active);
      check("cyc_busy",        bus.busy,        m_active);
      check("cyc_in_rd_en",    bus.in_rd_en,    e_rd);
      check("cyc_in_rd_addr",  bus.in_rd_addr,  e_addr);
      check("cyc_acc_clr",     bus.acc_clr,     e_clr);
      check("cyc_pe_en",       bus.pe_en,       e_pe);
      check("cyc_out_valid",   bus.out_valid,   e_ov);
      if (reset) begin
        if (!m_active) begin
          if (bus.start_valid) begin
            m_active = 1'b1;
            m_k      = int'(bus.k_len);
            m_d      = 1;
          end
        end else if (e_ov && bus.out_ready) begin
          m_active = 1'b0;
        end else begin
          m_d++;
        end
      end
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!bus.start_ready && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 1000) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic run_tile(input int k, input bit lit, input int e_lat, input int e_rdn,
                          input int e_pen, input int hold);
    int lat, rd, pe, clr;
    wait_ready();
    bus.start_valid = 1'b1;
    bus.k_len       = k[KW-1:0];
    bus.out_ready   = 1'b0;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.k_len       = 8'($urandom);
    lat = 0; rd = 0; pe = 0; clr = 0;
    for (int c = 1; c <= 400; c++) begin
      if (bus.in_rd_en) rd++;
      if (bus.pe_en)    pe++;
      if (bus.acc_clr)  clr++;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) check("out_valid_timeout", 0, 1);
    if (lit) begin
      check("tile_latency", lat, e_lat);
      check("tile_rd_cycles", rd, e_rdn);
      check("tile_pe_cycles", pe, e_pen);
      check("tile_clr_cycles", clr, 1);
    end
    for (int i = 0; i < hold; i++) begin
      bus.start_valid = 1'($urandom_range(0, 1));
      bus.k_len       = 8'($urandom);
      @(posedge clk); #1;
      if (lit) begin
        check("hold_out_valid", bus.out_valid, 1);
        check("hold_pe_en", bus.pe_en, 0);
      end
    end
    bus.start_valid = 1'b0;
    bus.out_ready   = 1'b1;
    @(posedge clk); #1;
    bus.out_ready   = 1'b0;
    check("return_idle", bus.start_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_valid = 1'b0;
    bus.k_len       = '0;
    bus.out_ready   = 1'b0;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_busy",        bus.busy, 0);
    check("rst_in_rd_en",    bus.in_rd_en, 0);
    check("rst_in_rd_addr",  bus.in_rd_addr, 0);
    check("rst_acc_clr",     bus.acc_clr, 0);
    check("rst_pe_en",       bus.pe_en, 0);
    check("rst_out_valid",   bus.out_valid, 0);

`ifdef SYSTOLIC_SCHED_PERF_CNT_EN
    repeat (3) run_tile(5, 1'b1, 25, 5, 24, 0);
    check("perf_tiles", perf_tiles, 3);
    check("perf_busy",  perf_busy, 75);
`endif

    run_tile(5, 1'b1, 25, 5, 24, 0);
    run_tile(0, 1'b1, 1, 0, 0, 0);
    run_tile(7, 1'b1, 27, 7, 26, 10);

    // Abandon a k_len=8 tile in its third LOAD cycle.
    wait_ready();
    bus.start_valid = 1'b1;
    bus.k_len       = 8'd8;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("load3_in_rd_en", bus.in_rd_en, 1);
    check("load3_addr", bus.in_rd_addr, 2);
    reset = 1'b0;
    #1;
    check("midrst_start_ready", bus.start_ready, 1);
    check("midrst_busy",        bus.busy, 0);
    check("midrst_in_rd_en",    bus.in_rd_en, 0);
    check("midrst_in_rd_addr",  bus.in_rd_addr, 0);
    check("midrst_acc_clr",     bus.acc_clr, 0);
    check("midrst_pe_en",       bus.pe_en, 0);
    check("midrst_out_valid",   bus.out_valid, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    run_tile(2, 1'b1, 22, 2, 21, 0);

    for (int t = 0; t < 40; t++) begin
      int k;
      k = (t == 5) ? 255 : $urandom_range(0, 24);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      run_tile(k, 1'b0, 0, 0, 0, $urandom_range(0, 4));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_tile_sched.md
SYSTOLIC_TILE_SCHED -- requirements
Module: systolic_tile_sched

Interface
REQ-001 SHALL have parameter SYSTOLIC_ROW, default 4, giving the input-skew rows of the array.
REQ-002 SHALL have parameter SYSTOLIC_COLUMN, default 16, giving the output-deskew columns per PE block.
REQ-003 SHALL have parameter K_WIDTH, default 8, giving the width of the reduction length and of the read address.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start_valid  input  1  tile request.
REQ-007 start_ready  output  1  scheduler can accept a tile.
REQ-008 k_len  input  K_WIDTH  reduction length of the tile, sampled at accept.
REQ-009 in_rd_en  output  1  operand buffer read strobe feeding the input skew stage.
REQ-010 in_rd_addr  output  K_WIDTH  operand buffer read address.
REQ-011 acc_clr  output  1  one-cycle clear of the PE accumulators.
REQ-012 pe_en  output  1  array and staging shift enable.
REQ-013 out_valid  output  1  deskewed tile result is stable at the staging outputs.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, FLUSH and DONE, held in a registered state variable.
REQ-017 SHALL drive start_ready high only in IDLE; accept occurs at cycle T when start_valid && start_ready.
REQ-018 On accept with k_len>0, SHALL latch k_len and enter LOAD at T+1.
REQ-019 On accept with k_len==0, SHALL enter DONE at T+1 and never assert in_rd_en.
REQ-020 SHALL assert acc_clr for exactly the cycle T+1 on every accept, including k_len==0.
REQ-021 In LOAD, SHALL assert in_rd_en for exactly k_len consecutive cycles, T+1..T+k_len, with in_rd_addr 0,1,...,k_len-1.
REQ-022 SHALL hold in_rd_addr at 0 whenever in_rd_en is low.
REQ-023 After the last LOAD cycle, SHALL enter FLUSH for exactly FLUSH_LEN = SYSTOLIC_ROW+SYSTOLIC_COLUMN-1 cycles (19 at the defaults).
REQ-024 SHALL hold pe_en high throughout LOAD and FLUSH and low in IDLE and DONE, so the array is frozen while the result is held.
REQ-025 In DONE, SHALL hold out_valid high until out_ready is sampled high, then return to IDLE on the next cycle.
REQ-026 SHALL not present start_ready in the out_valid && out_ready cycle; a back-to-back start is accepted one cycle later, in IDLE.
REQ-027 SHALL ignore start_valid and k_len changes in every state except IDLE.
REQ-028 SHALL size the LOAD and FLUSH down-counters to hold max(2^K_WIDTH-1, FLUSH_LEN) without wrap.

Reset
REQ-029 While reset is low, SHALL force state to IDLE and drive the following outputs and counters: start_ready=1, busy=0, in_rd_en=0, in_rd_addr=0, acc_clr=0, pe_en=0, out_valid=0, counters=0.
REQ-030 A reset asserted mid-tile SHALL abandon the tile with no further acc_clr or out_valid; the first accept after release behaves as from power-up.

Configuration
REQ-031 With macro SYSTOLIC_SCHED_PERF_CNT_EN defined, SHALL add outputs perf_tiles[31:0], incremented on each out_valid && out_ready, and perf_busy[31:0], incremented each cycle busy is high; both wrap at 2^32 and reset to 0.
REQ-032 Without SYSTOLIC_SCHED_PERF_CNT_EN, SHALL omit both ports and their counters, leaving all other behaviour identical.

Structure
REQ-033 SHALL place the state encoding, typed as sched_state_t with IDLE=0, LOAD=1, FLUSH=2, DONE=3, in the shared package mha_pkg.
REQ-034 SHALL place the FLUSH_LEN derivation function in the shared package mha_pkg.
REQ-035 SHALL implement the reusable loadable down-counter as the single sub-module sched_down_cnt, instantiated for LOAD and FLUSH.

Verification
REQ-036 Bench SHALL cover: reset low 3 cycles then released -> start_ready=1, busy=0, all other outputs 0.
REQ-037 Bench SHALL cover: k_len=5 accepted at T -> acc_clr at T+1 only; in_rd_en T+1..T+5 with addr 0..4; pe_en T+1..T+24; out_valid from T+25.
REQ-038 Bench SHALL cover: k_len=0 -> acc_clr at T+1; out_valid from T+1; in_rd_en never high; pe_en never high.
REQ-039 Bench SHALL cover: out_ready held low 10 cycles in DONE -> out_valid stays high, pe_en stays low, start_valid ignored; release -> IDLE next cycle.
REQ-040 Bench SHALL cover: reset pulsed low at LOAD cycle 3 of k_len=8 -> all outputs 0 immediately; a new k_len=2 tile then completes with out_valid at accept+22.
REQ-041 Bench SHALL cover: with SYSTOLIC_SCHED_PERF_CNT_EN, three k_len=5 tiles with out_ready tied high -> perf_tiles=3, perf_busy=75.
